// File: rtl/token_pkg.sv
// Shared types and constants for the turn-based token movement controller.
package token_pkg;

  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    WAIT_ROLL = 2'd0,
    MOVE      = 2'd1,
    END_TURN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  // Packed start positions, token i at bits [10i+9:10i].
  localparam logic [4*COORD_W-1:0] RESET_POS_X = {10'd180, 10'd520, 10'd240, 10'd400};
  localparam logic [4*COORD_W-1:0] RESET_POS_Y = {10'd300, 10'd150, 10'd30,  10'd30};

endpackage

// File: rtl/btn_edge_detect.sv
// Registers one debounced button level and emits a single-cycle pulse on its rising edge.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/token_move_scheduler.sv
// Turn-based token movement: dice-roll step budget, one grid step per button press,
// positions committed only on frame_end so the display never tears.
module token_move_scheduler
  import token_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int STEP        = 20,
  parameter int X_MIN       = 20,
  parameter int X_MAX       = 620,
  parameter int Y_MIN       = 20,
  parameter int Y_MAX       = 460,
  parameter int MAX_ROLL    = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_end,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_confirm,
  input  logic                           roll_valid,
  input  logic [3:0]                     roll_value,
  output logic                           roll_ready,
  output logic [COORD_W*NUM_PLAYERS-1:0] pos_x,
  output logic [COORD_W*NUM_PLAYERS-1:0] pos_y,
  output logic [1:0]                     active_player,
  output logic [3:0]                     steps_left,
  output logic                           move_reject,
  output logic                           turn_done
);

  typedef logic signed [COORD_W:0] scoord_t;
  typedef logic [NUM_PLAYERS-1:0][COORD_W-1:0] pos_arr_t;

  state_t   state_q, state_d;
  dir_t     dir_q, dir_d, dir_press;
  logic     pend_q, pend_d;
  logic     reject_q, reject_d;
  logic [1:0] active_q, active_d;
  logic [3:0] steps_q, steps_d;
  pos_arr_t pos_x_q, pos_x_d, pos_y_q, pos_y_d;

  logic up_p, down_p, left_p, right_p, conf_p;
  scoord_t cur_x, cur_y, cand_x, cand_y;
  logic in_bounds, collide;

  btn_edge_detect u_up    (.clk(clk), .rst(reset), .btn_i(btn_up),      .press_o(up_p));
  btn_edge_detect u_down  (.clk(clk), .rst(reset), .btn_i(btn_down),    .press_o(down_p));
  btn_edge_detect u_left  (.clk(clk), .rst(reset), .btn_i(btn_left),    .press_o(left_p));
  btn_edge_detect u_right (.clk(clk), .rst(reset), .btn_i(btn_right),   .press_o(right_p));
  btn_edge_detect u_conf  (.clk(clk), .rst(reset), .btn_i(btn_confirm), .press_o(conf_p));

  always_comb begin
    dir_press = DIR_NONE;
    if      (up_p)    dir_press = DIR_UP;
    else if (down_p)  dir_press = DIR_DOWN;
    else if (left_p)  dir_press = DIR_LEFT;
    else if (right_p) dir_press = DIR_RIGHT;
  end

  // Candidate is signed and one bit wider so stepping below 0 shows up as negative.
  always_comb begin
    cur_x  = scoord_t'({1'b0, pos_x_q[active_q]});
    cur_y  = scoord_t'({1'b0, pos_y_q[active_q]});
    cand_x = cur_x;
    cand_y = cur_y;
    case (dir_q)
      DIR_UP:    cand_y = cur_y - scoord_t'(STEP);
      DIR_DOWN:  cand_y = cur_y + scoord_t'(STEP);
      DIR_LEFT:  cand_x = cur_x - scoord_t'(STEP);
      DIR_RIGHT: cand_x = cur_x + scoord_t'(STEP);
      default:   ;
    endcase
    in_bounds = (cand_x >= scoord_t'(X_MIN)) && (cand_x <= scoord_t'(X_MAX)) &&
                (cand_y >= scoord_t'(Y_MIN)) && (cand_y <= scoord_t'(Y_MAX));
    collide = 1'b0;
    for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
      if (2'(j) != active_q &&
          cand_x == scoord_t'({1'b0, pos_x_q[2'(j)]}) &&
          cand_y == scoord_t'({1'b0, pos_y_q[2'(j)]}))
        collide = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    steps_d  = steps_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    reject_d = 1'b0;
    case (state_q)
      WAIT_ROLL: begin
        if (roll_valid) begin
          steps_d = (roll_value > 4'(MAX_ROLL)) ? 4'(MAX_ROLL) : roll_value;
          state_d = (roll_value == 4'd0) ? END_TURN : MOVE;
        end
      end
      MOVE: begin
        // Confirm wins even over a move that would apply on this same frame_end.
        if (conf_p) begin
          pend_d  = 1'b0;
          dir_d   = DIR_NONE;
          state_d = END_TURN;
        end else if (pend_q && frame_end) begin
          pend_d = 1'b0;
          dir_d  = DIR_NONE;
          if (in_bounds && !collide) begin
            pos_x_d[active_q] = cand_x[COORD_W-1:0];
            pos_y_d[active_q] = cand_y[COORD_W-1:0];
            steps_d = steps_q - 4'd1;
            if (steps_q == 4'd1) state_d = END_TURN;
          end else begin
            reject_d = 1'b1;
          end
        end else if (!pend_q && dir_press != DIR_NONE) begin
          pend_d = 1'b1;
          dir_d  = dir_press;
        end
      end
      END_TURN: begin
        steps_d  = '0;
        active_d = (active_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : active_q + 2'd1;
        state_d  = WAIT_ROLL;
      end
      default: state_d = WAIT_ROLL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_ROLL;
      active_q <= '0;
      steps_q  <= '0;
      pend_q   <= 1'b0;
      dir_q    <= DIR_NONE;
      reject_q <= 1'b0;
      pos_x_q  <= RESET_POS_X;
      pos_y_q  <= RESET_POS_Y;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      steps_q  <= steps_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      reject_q <= reject_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  assign roll_ready    = (state_q == WAIT_ROLL);
  assign turn_done     = (state_q == END_TURN);
  assign move_reject   = reject_q;
  assign active_player = active_q;
  assign steps_left    = steps_q;
  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;

endmodule

// File: tb/tb_token_move_scheduler.sv
// Directed self-checking bench for token_move_scheduler.
module tb_token_move_scheduler;

  logic clk = 1'b0;
  logic reset, frame_end, btn_up, btn_down, btn_left, btn_right, btn_confirm;
  logic roll_valid;
  logic [3:0] roll_value;
  logic roll_ready, move_reject, turn_done;
  logic [39:0] pos_x, pos_y;
  logic [1:0] active_player;
  logic [3:0] steps_left;

  int total = 0;
  int bad = 0;
  int td_cnt = 0;

  token_move_scheduler #(.NUM_PLAYERS(4), .STEP(20), .MAX_ROLL(12)) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_confirm(btn_confirm), .roll_valid(roll_valid), .roll_value(roll_value),
    .roll_ready(roll_ready), .pos_x(pos_x), .pos_y(pos_y),
    .active_player(active_player), .steps_left(steps_left),
    .move_reject(move_reject), .turn_done(turn_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (turn_done === 1'b1) td_cnt++;

  function automatic logic [9:0] tx(input int i);
    return pos_x[10*i +: 10];
  endfunction
  function automatic logic [9:0] ty(input int i);
    return pos_y[10*i +: 10];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic roll(input logic [3:0] v);
    roll_valid = 1'b1; roll_value = v; tick(); roll_valid = 1'b0;
  endtask

  task automatic frame();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
  endtask

  task automatic confirm();
    btn_confirm = 1'b1; tick(); btn_confirm = 1'b0;
  endtask

  task automatic test_reset();
    int ex[4] = '{400, 240, 520, 180};
    int ey[4] = '{30, 30, 150, 300};
    for (int i = 0; i < 4; i++) begin
      total++; if (tx(i) !== 10'(ex[i])) begin bad++; $display("FAIL rst_x%0d got=%0d exp=%0d", i, tx(i), ex[i]); end
      total++; if (ty(i) !== 10'(ey[i])) begin bad++; $display("FAIL rst_y%0d got=%0d exp=%0d", i, ty(i), ey[i]); end
    end
    total++; if (active_player !== 2'd0) begin bad++; $display("FAIL rst_active got=%0d exp=0", active_player); end
    total++; if (steps_left !== 4'd0) begin bad++; $display("FAIL rst_steps got=%0d exp=0", steps_left); end
    total++; if (roll_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", roll_ready); end
    total++; if (move_reject !== 1'b0 || turn_done !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%0b%0b exp=00", move_reject, turn_done); end
  endtask

  task automatic test_roll_right();
    roll(4'd3);
    total++; if (steps_left !== 4'd3) begin bad++; $display("FAIL roll3_steps got=%0d exp=3", steps_left); end
    total++; if (roll_ready !== 1'b0) begin bad++; $display("FAIL roll3_ready got=%0b exp=0", roll_ready); end
    btn_right = 1'b1; tick(); btn_right = 1'b0;
    repeat (3) tick();
    total++; if (tx(0) !== 10'd400) begin bad++; $display("FAIL right_stable got=%0d exp=400", tx(0)); end
    frame();
    total++; if (tx(0) !== 10'd420 || ty(0) !== 10'd30) begin bad++; $display("FAIL right_pos got=(%0d,%0d) exp=(420,30)", tx(0), ty(0)); end
    total++; if (steps_left !== 4'd2) begin bad++; $display("FAIL right_steps got=%0d exp=2", steps_left); end
    total++; if (move_reject !== 1'b0) begin bad++; $display("FAIL right_noreject got=%0b exp=0", move_reject); end
  endtask

  task automatic test_hold();
    btn_down = 1'b1;
    repeat (5) begin repeat (2) tick(); frame(); end
    btn_down = 1'b0; tick();
    total++; if (tx(0) !== 10'd420 || ty(0) !== 10'd50) begin bad++; $display("FAIL hold_pos got=(%0d,%0d) exp=(420,50)", tx(0), ty(0)); end
    total++; if (steps_left !== 4'd1) begin bad++; $display("FAIL hold_steps got=%0d exp=1", steps_left); end
    confirm();
    total++; if (turn_done !== 1'b1) begin bad++; $display("FAIL confirm_done got=%0b exp=1", turn_done); end
    tick();
    total++; if (active_player !== 2'd1 || turn_done !== 1'b0) begin bad++; $display("FAIL confirm_next got=%0d/%0b exp=1/0", active_player, turn_done); end
    total++; if (steps_left !== 4'd0 || roll_ready !== 1'b1) begin bad++; $display("FAIL confirm_wait got=%0d/%0b exp=0/1", steps_left, roll_ready); end
  endtask

  task automatic test_bounds_reject();
    roll(4'd4);
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    frame();
    total++; if (move_reject !== 1'b1) begin bad++; $display("FAIL bound_reject got=%0b exp=1", move_reject); end
    total++; if (tx(1) !== 10'd240 || ty(1) !== 10'd30) begin bad++; $display("FAIL bound_pos got=(%0d,%0d) exp=(240,30)", tx(1), ty(1)); end
    total++; if (steps_left !== 4'd4) begin bad++; $display("FAIL bound_steps got=%0d exp=4", steps_left); end
    tick();
    total++; if (move_reject !== 1'b0) begin bad++; $display("FAIL bound_pulse got=%0b exp=0", move_reject); end
    btn_down = 1'b1; btn_right = 1'b1; tick(); btn_down = 1'b0; btn_right = 1'b0;
    frame();
    total++; if (tx(1) !== 10'd240 || ty(1) !== 10'd50) begin bad++; $display("FAIL prio_pos got=(%0d,%0d) exp=(240,50)", tx(1), ty(1)); end
    total++; if (steps_left !== 4'd3) begin bad++; $display("FAIL prio_steps got=%0d exp=3", steps_left); end
    btn_right = 1'b1; tick(); btn_right = 1'b0;
    btn_confirm = 1'b1; frame_end = 1'b1; tick(); btn_confirm = 1'b0; frame_end = 1'b0;
    total++; if (turn_done !== 1'b1 || tx(1) !== 10'd240) begin bad++; $display("FAIL confdisc got=%0b/%0d exp=1/240", turn_done, tx(1)); end
    tick();
    total++; if (active_player !== 2'd2) begin bad++; $display("FAIL confdisc_next got=%0d exp=2", active_player); end
  endtask

  task automatic test_collision();
    reset = 1'b1; tick(); reset = 1'b0; tick();
    roll(4'd7);
    repeat (7) begin btn_left = 1'b1; tick(); btn_left = 1'b0; tick(); frame(); end
    total++; if (turn_done !== 1'b1 || steps_left !== 4'd0) begin bad++; $display("FAIL run7_end got=%0b/%0d exp=1/0", turn_done, steps_left); end
    total++; if (tx(0) !== 10'd260) begin bad++; $display("FAIL run7_x got=%0d exp=260", tx(0)); end
    tick();
    roll(4'd0);
    total++; if (turn_done !== 1'b1) begin bad++; $display("FAIL roll0_done got=%0b exp=1", turn_done); end
    tick();
    total++; if (active_player !== 2'd2 || roll_ready !== 1'b1) begin bad++; $display("FAIL roll0_next got=%0d/%0b exp=2/1", active_player, roll_ready); end
    roll(4'd0); tick();
    roll(4'd5); confirm();
    total++; if (turn_done !== 1'b1 || active_player !== 2'd3) begin bad++; $display("FAIL p3_done got=%0b/%0d exp=1/3", turn_done, active_player); end
    tick();
    total++; if (active_player !== 2'd0) begin bad++; $display("FAIL wrap got=%0d exp=0", active_player); end
    roll(4'd3);
    btn_left = 1'b1; tick(); btn_left = 1'b0;
    frame();
    total++; if (move_reject !== 1'b1) begin bad++; $display("FAIL coll_reject got=%0b exp=1", move_reject); end
    total++; if (tx(0) !== 10'd260 || steps_left !== 4'd3) begin bad++; $display("FAIL coll_keep got=%0d/%0d exp=260/3", tx(0), steps_left); end
  endtask

  task automatic test_roll_clamp();
    confirm(); tick();
    roll(4'd15);
    total++; if (steps_left !== 4'd12) begin bad++; $display("FAIL clamp got=%0d exp=12", steps_left); end
  endtask

  task automatic test_turn_two();
    confirm(); tick();
    td_cnt = 0;
    roll(4'd2);
    repeat (2) begin btn_right = 1'b1; tick(); btn_right = 1'b0; tick(); frame(); end
    tick();
    total++; if (roll_ready !== 1'b1 || active_player !== 2'd3) begin bad++; $display("FAIL turn2_next got=%0b/%0d exp=1/3", roll_ready, active_player); end
    repeat (3) tick();
    total++; if (td_cnt !== 1) begin bad++; $display("FAIL turn2_pulses got=%0d exp=1", td_cnt); end
    total++; if (tx(2) !== 10'd560 || ty(2) !== 10'd150) begin bad++; $display("FAIL turn2_pos got=(%0d,%0d) exp=(560,150)", tx(2), ty(2)); end
  endtask

  task automatic test_reset_pending();
    roll(4'd3);
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    reset = 1'b1; #3;
    total++; if (tx(0) !== 10'd400 || tx(2) !== 10'd520) begin bad++; $display("FAIL async_rst got=%0d/%0d exp=400/520", tx(0), tx(2)); end
    reset = 1'b0; tick();
    roll_valid = 1'b0; frame();
    total++; if (tx(3) !== 10'd180 || ty(3) !== 10'd300) begin bad++; $display("FAIL rstpend_pos got=(%0d,%0d) exp=(180,300)", tx(3), ty(3)); end
    total++; if (active_player !== 2'd0 || steps_left !== 4'd0) begin bad++; $display("FAIL rstpend_state got=%0d/%0d exp=0/0", active_player, steps_left); end
    btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
    roll(4'd2);
    frame(); tick();
    total++; if (tx(0) !== 10'd400 || steps_left !== 4'd2) begin bad++; $display("FAIL waitpress got=%0d/%0d exp=400/2", tx(0), steps_left); end
  endtask

  initial begin
    reset = 1'b1; frame_end = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
    btn_right = 1'b0; btn_confirm = 1'b0; roll_valid = 1'b0; roll_value = 4'd0;
    tick(); tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_roll_right();
    test_hold();
    test_bounds_reject();
    test_collision();
    test_roll_clamp();
    test_turn_two();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/token_move_scheduler.md
Name: token_move_scheduler

Overview:
- Turn-based movement controller for the four player tokens drawn by the VGA top level.
- Replaces the per-frame, switch-selected, free-running square movement with one grid step per debounced button press.
- The active player is chosen round-robin. Each turn's step budget comes from a dice-roll handshake with the processor wrapper.
- Token positions are the only source of sprite coordinates for the display path. They change only on the frame-end strobe, so a frame never tears.

Parameters:
- NUM_PLAYERS, 4, number of tokens; the rules below are written for 4.
- STEP, 20, pixels moved per accepted step (one board grid cell).
- X_MIN, 20, smallest legal token centre x.
- X_MAX, 620, largest legal token centre x.
- Y_MIN, 20, smallest legal token centre y.
- Y_MAX, 460, largest legal token centre y.
- MAX_ROLL, 12, largest step budget accepted.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_end  in  1  single-clk-cycle pulse between frames; the clk-synchronous version of screenEnd.
- btn_up / btn_down / btn_left / btn_right  in  1 each  debounced direction button levels.
- btn_confirm  in  1  debounced centre button level; ends the turn early.
- roll_valid  in  1  dice value offered by the processor.
- roll_value  in  4  dice value.
- roll_ready  out  1  high while in WAIT_ROLL.
- pos_x  out  40  packed token centre x, 10 bits per token; token i occupies bits [10i+9:10i].
- pos_y  out  40  packed token centre y, same packing as pos_x.
- active_player  out  2  index of the token whose turn it is.
- steps_left  out  4  remaining step budget.
- move_reject  out  1  one-cycle pulse when a pending move is refused.
- turn_done  out  1  one-cycle pulse when a turn ends.

Behaviour:
- Reset values (asynchronous):
  - state = WAIT_ROLL, active_player = 0, steps_left = 0.
  - pending move cleared; move_reject = 0; turn_done = 0.
  - Edge-detect registers cleared to 0.
  - Positions: token0 (400,30), token1 (240,30), token2 (520,150), token3 (180,300).
- Reset mid-turn: everything above is restored and any pending move is discarded.
- Edge detect: each button is registered once. A press is a 0->1 transition. A held button yields exactly one press.
- WAIT_ROLL:
  - roll_ready = 1. A transfer happens on a clk edge where roll_valid && roll_ready.
  - steps_left <= min(roll_value, MAX_ROLL).
  - roll_value 0 -> go to END_TURN; otherwise go to MOVE.
  - Button presses in this state are ignored.
- MOVE, latching a move:
  - A direction press with no move pending latches that direction; the pending flag is set the cycle after the press.
  - Several direction presses in the same cycle: priority up > down > left > right; the rest are dropped.
  - Presses while a move is already pending are dropped.
- MOVE, applying a move (on the frame_end cycle while pending):
  - Candidate = current position ±STEP on one axis.
  - Reject if the candidate is outside [X_MIN,X_MAX] or [Y_MIN,Y_MAX]. Compare in 11-bit signed arithmetic so that 20-20 and wrap below 0 are caught.
  - Reject if the candidate equals another token's (x,y).
  - On reject: move_reject pulses, the position is unchanged, steps_left is unchanged, the pending flag is cleared.
  - On accept: the position updates and steps_left decrements, both visible the cycle after frame_end; the pending flag is cleared.
  - Accepted move that makes steps_left 0 -> END_TURN.
- MOVE, confirm press -> END_TURN. Any pending move is discarded, including one coinciding with the same frame_end.
- END_TURN (one cycle):
  - turn_done = 1, steps_left <= 0.
  - active_player <= (active_player + 1) mod 4, wrapping 3 -> 0.
  - Then WAIT_ROLL.
- frame_end outside MOVE has no effect.
- Latency:
  - Press to pending: 1 cycle.
  - Pending to position: the next frame_end plus 1 cycle.
  - Roll transfer to MOVE: 1 cycle.

Decomposition:
- Shared package token_pkg holds:
  - the state enum (WAIT_ROLL, MOVE, END_TURN);
  - the direction encoding (NONE, UP, DOWN, LEFT, RIGHT);
  - the reset position table;
  - the coordinate width constant (10).
- One natural sub-module, btn_edge_detect: a per-button register plus rising-edge pulse, instantiated 5 times.
- Bounds and collision checking stays combinational inside the top.

Test Plan:
- Reset, then roll 3, then right press, then frame_end -> token0 = (420,30), steps_left = 2, position stable before frame_end.
- Hold btn_down for 5 frames -> exactly one step: token0 y 30 -> 50.
- Token1 at (240,30), press up -> candidate y = 10 < Y_MIN -> move_reject pulses; position and steps_left unchanged.
- Token0 at (260,30), token1 at (240,30), token0's turn, press left -> collision reject; no change.
- Roll 2, accept 2 moves -> turn_done pulses once, active_player 0 -> 1; roll_ready high the next cycle.
- Active_player 3 with confirm pressed -> turn_done, active_player wraps to 0.
- Roll 0 -> immediate END_TURN.
- Roll 15 -> steps_left = 12.
- Assert reset while a move is pending -> all tokens return to their reset positions; no move is applied at the next frame_end.
